// File: rtl/serial_cla_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// serial_cla_add_seq_pkg
//   Shared constants for the nibble-serial CLA adder.
//   - state_e : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - NIB_W   : width of one beat of the shared CLA slice
// ---------------------------------------------------------------------------
package serial_cla_add_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_cla_add_seq_cla4bit.sv
// ---------------------------------------------------------------------------
// cla4bit
//   Combinational 4-bit carry-lookahead slice.
//   Ports:
//     a_i, b_i  [3:0]  operand nibbles
//     cin_i            carry in
//     sum_o     [3:0]  sum nibble
//     cout_o           carry out of bit 3
// ---------------------------------------------------------------------------
module cla4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        // Every carry is a flat function of cin and the g/p terms.
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & cin_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin_i);
        sum_o  = p ^ c[3:0];
        cout_o = c[4];
    end

endmodule

// File: rtl/serial_cla_add_seq.sv
// ---------------------------------------------------------------------------
// serial_cla_add_seq
//   Multi-cycle W-bit adder (W = 4*NIBBLES) that reuses one 4-bit CLA slice
//   over NIBBLES beats, LSB nibble first, with a registered carry between
//   beats. Low-area alternative to the single-cycle carry-increment adder.
//
//   Optional feature macro: SERIAL_CLA_SUB_EN
//     Adds input sub_i; when set at accept, computes a - b
//     (b inverted at capture, beat-0 carry-in = 1, cout = 1 means no borrow).
//
//   Ports:
//     clk_i          clock, rising edge
//     rst_i          asynchronous active-high reset
//     in_valid_i     operands presented
//     in_ready_o     block can accept operands (IDLE)
//     a_i, b_i [W]   operands, captured at accept
//     sub_i          subtract select (SERIAL_CLA_SUB_EN only)
//     out_valid_o    result valid (DONE)
//     out_ready_i    consumer accepts result
//     r_o      [W]   sum mod 2^W
//     cout_o         carry out of bit W-1
//     overflow_o     signed overflow
//     busy_o         high while beats are running
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | waiting for operands, in_ready high
//   RUN     | one nibble per cycle through the CLA slice
//   DONE    | result held with out_valid until out_ready
// ---------------------------------------------------------------------------
module serial_cla_add_seq
    import serial_cla_add_seq_pkg::*;
#(
    parameter int NIBBLES = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [NIB_W*NIBBLES-1:0] a_i,
    input  logic [NIB_W*NIBBLES-1:0] b_i,
`ifdef SERIAL_CLA_SUB_EN
    input  logic                   sub_i,
`endif
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [NIB_W*NIBBLES-1:0] r_o,
    output logic                   cout_o,
    output logic                   overflow_o,
    output logic                   busy_o
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     r_q, r_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [W-1:0]     b_cap;
    logic             cin0;
    logic [NIB_W-1:0] slice_sum;
    logic             slice_cout;

`ifdef SERIAL_CLA_SUB_EN
    assign b_cap = sub_i ? ~b_i : b_i;
    assign cin0  = sub_i;
`else
    assign b_cap = b_i;
    assign cin0  = 1'b0;
`endif

    cla4bit u_cla (
        .a_i    (a_sh_q[NIB_W-1:0]),
        .b_i    (b_sh_q[NIB_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        carry_d     = carry_q;
        r_d         = r_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_cap;
                    carry_d = cin0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                r_d     = {slice_sum, r_q[W-1:NIB_W]};
                carry_d = slice_cout;
                a_sh_d  = a_sh_q >> NIB_W;
                b_sh_d  = b_sh_q >> NIB_W;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // On the last beat the shift regs hold the top nibble,
                    // so bit 3 of each is the captured operand sign. Using
                    // the captured (possibly inverted) b makes the add-form
                    // overflow equal the subtract-form overflow.
                    cout_d      = slice_cout;
                    ovf_d       = (a_sh_q[NIB_W-1] ^ slice_sum[NIB_W-1])
                                & (b_sh_q[NIB_W-1] ^ slice_sum[NIB_W-1]);
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            carry_q     <= 1'b0;
            r_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            carry_q     <= carry_d;
            r_q         <= r_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_RUN);
    assign out_valid_o = out_valid_q;
    assign r_o         = r_q;
    assign cout_o      = cout_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_serial_cla_add_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_cla_add_seq
//   Scoreboard bench: the driver pushes hand-computed results at accept,
//   the monitor pops and compares on each output handshake and checks the
//   accept-to-out_valid latency. Define SERIAL_CLA_SUB_EN to add subtract
//   vectors.
// ---------------------------------------------------------------------------
module tb_serial_cla_add_seq;

    localparam int NIB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r;
    logic        cout;
    logic        ovf;
    logic        busy;

    serial_cla_add_seq #(.NIBBLES(NIB)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a_in),
        .b_i         (b_in),
`ifdef SERIAL_CLA_SUB_EN
        .sub_i       (sub),
`endif
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .r_o         (r),
        .cout_o      (cout),
        .overflow_o  (ovf),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: latency on out_valid rise, result compare on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_v) begin
            if (q.size() == 0) check("pending_on_valid", 0, 1);
            else               check("latency", 32'(cyc - q[0].acc), NIB);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) check("pending_on_handshake", 0, 1);
            else begin
                e = q.pop_front();
                check("r", r, e.r);
                check("cout", {31'b0, cout}, {31'b0, e.c});
                check("overflow", {31'b0, ovf}, {31'b0, e.o});
            end
        end
        prev_v = out_valid;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic push, input logic [31:0] er, input logic ec,
                         input logic eo);
        int t = 0;
        @(posedge clk); #1;
        a_in = a; b_in = b; sub = s; in_valid = 1'b1;
`ifndef SERIAL_CLA_SUB_EN
        if (s) check("sub_unsupported", {31'b0, s}, 0);
`endif
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'b0, in_ready}, 1);
            in_valid = 1'b0;
            return;
        end
        if (push) q.push_back('{er, ec, eo, cyc + 1});
        @(posedge clk); #1;
        // Scramble inputs after accept: result must use captured operands.
        in_valid = 1'b0; a_in = 32'hDEADBEEF; b_in = 32'h0BADF00D; sub = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || !in_ready) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending", q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 1);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_r", r, 0);
        check("rst_cout", {31'b0, cout}, 0);
        check("rst_ovf", {31'b0, ovf}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        rst = 1'b0;

        issue(32'h00000001, 32'h00000001, 0, 1, 32'h00000002, 0, 0);
        #2 check("busy_in_run", {31'b0, busy}, 1);
        issue(32'hFFFFFFFF, 32'h00000001, 0, 1, 32'h00000000, 1, 0);
        issue(32'h7FFFFFFF, 32'h00000001, 0, 1, 32'h80000000, 0, 1);
        issue(32'h80000000, 32'h80000000, 0, 1, 32'h00000000, 1, 1);
        issue(32'h0F0F0F0F, 32'h01010101, 0, 1, 32'h10101010, 0, 0);
        drain();

        // Back-pressure in DONE.
        out_ready = 1'b0;
        issue(32'hA5A5A5A5, 32'h5A5A5A5A, 0, 1, 32'hFFFFFFFF, 0, 0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_reach_done", {31'b0, out_valid}, 1);
        in_valid = 1'b1; a_in = 32'h00000003; b_in = 32'h00000004;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_r_stable", r, 32'hFFFFFFFF);
            check("bp_in_ready", {31'b0, in_ready}, 0);
            check("bp_out_valid", {31'b0, out_valid}, 1);
        end
        q.push_back('{32'h00000007, 1'b0, 1'b0, cyc + 2});
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after_hs", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepted", {31'b0, busy}, 1);
        drain();

        // Reset mid-RUN at beat 4.
        issue(32'h12345678, 32'h11111111, 0, 0, 32'h0, 0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_r", r, 0);
        check("abort_cout", {31'b0, cout}, 0);
        check("abort_ovf", {31'b0, ovf}, 0);
        check("abort_out_valid", {31'b0, out_valid}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1 rst = 1'b0;
        issue(32'h12345678, 32'h11111111, 0, 1, 32'h23456789, 0, 0);
        drain();

`ifdef SERIAL_CLA_SUB_EN
        issue(32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0);
        issue(32'h80000000, 32'h00000001, 1, 1, 32'h7FFFFFFF, 1, 1);
        issue(32'h00000009, 32'h00000004, 1, 1, 32'h00000005, 1, 0);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
